if_fetch_unit: RTL and testbench

Instruction-fetch front end of the 5-stage pipeline; it produces the instruction stream that the decode stage registers on every clock. It holds the PC, issues one-outstanding word reads to instruction memory over a req/ack handshake, and buffers returned words in a 2-entry FIFO so decode stalls do not lose fetched instructions. It accepts branch redirects from decode and tags each delivered instruction with a type class and a wrapping sequence number for the debug display.

---
 rtl/if_fetch_unit_if.sv | 30 +++
 rtl/if_fetch_unit.sv | 159 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Bundle between the fetch unit, instruction memory and the decode stage.
// The master side is the fetch unit; the slave side is memory plus decode.
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        id_branch;
    logic [31:0] id_branch_target;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc4;
    logic [3:0]  IF_ins_type;
    logic [3:0]  IF_ins_number;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  id_stall, id_branch, id_branch_target,
        output if_valid, if_inst, if_pc4, IF_ins_type, IF_ins_number
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output id_stall, id_branch, id_branch_target,
        input  if_valid, if_inst, if_pc4, IF_ins_type, IF_ins_number
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC, single-outstanding imem read, 2-entry
// instruction FIFO toward decode, and branch redirect with in-flight drop.
//   state | meaning
//   IDLE  | no request outstanding; waiting for FIFO space
//   WAIT  | request at fetch_pc outstanding; returned word is kept
//   DROP  | request at a pre-redirect address outstanding; word is discarded
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic             clk,
    input logic             rst,
    if_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
        logic [3:0]  itype;
    } entry_t;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    entry_t      ent0_q, ent0_d;
    entry_t      ent1_q, ent1_d;
    logic [1:0]  count_q, count_d;
    logic [3:0]  seq_q, seq_d;

    logic        fifo_valid;
    logic        branch;
    logic        pop;
    logic        push;
    entry_t      new_ent;

    function automatic logic [3:0] classify(input logic [5:0] opcode);
        logic [3:0] cls;
        case (opcode)
            6'h00:         cls = 4'd0;
            6'h23:         cls = 4'd1;
            6'h2B:         cls = 4'd2;
            6'h04, 6'h05:  cls = 4'd3;
            6'h02, 6'h03:  cls = 4'd4;
            default:       cls = 4'd5;
        endcase
        return cls;
    endfunction

    assign fifo_valid    = (count_q != 2'd0);
    assign branch        = bus.id_branch;
    assign pop           = fifo_valid && !bus.id_stall && !branch;
    assign push          = (state_q == ST_WAIT) && bus.imem_ack && !branch;
    assign new_ent.inst  = bus.imem_rdata;
    assign new_ent.pc4   = fetch_pc_q + 32'd4;
    assign new_ent.itype = classify(bus.imem_rdata[31:26]);

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        ent0_d      = ent0_q;
        ent1_d      = ent1_q;
        count_d     = count_q;
        seq_d       = seq_q;

        if (branch) begin
            count_d    = 2'd0;
            fetch_pc_d = bus.id_branch_target;
        end else begin
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            if (push) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            // ent0 is always the front; ent1 only matters when count is 2
            case ({push, pop})
                2'b01: ent0_d = ent1_q;
                2'b10: begin
                    if (count_q == 2'd0) begin
                        ent0_d = new_ent;
                    end else begin
                        ent1_d = new_ent;
                    end
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        ent0_d = new_ent;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = new_ent;
                    end
                end
                default: ;
            endcase
        end

        if (pop) begin
            seq_d = seq_q + 4'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!branch && count_d <= 2'd1) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.imem_ack) begin
                    if (count_d == 2'd2) begin
                        state_d = ST_IDLE;
                    end
                end else if (branch) begin
                    // memory still owes us the old word; remember where it was asked
                    state_d     = ST_DROP;
                    drop_addr_d = fetch_pc_q;
                end
            end
            ST_DROP: begin
                if (bus.imem_ack) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= RESET_PC;
            ent0_q      <= '0;
            ent1_q      <= '0;
            count_q     <= 2'd0;
            seq_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
            ent0_q      <= ent0_d;
            ent1_q      <= ent1_d;
            count_q     <= count_d;
            seq_q       <= seq_d;
        end
    end

    assign bus.imem_req      = (state_q != ST_IDLE);
    assign bus.imem_addr     = (state_q == ST_DROP) ? drop_addr_q : fetch_pc_q;
    assign bus.if_valid      = fifo_valid;
    assign bus.if_inst       = fifo_valid ? ent0_q.inst : 32'h0;
    assign bus.if_pc4        = fifo_valid ? ent0_q.pc4 : 32'h0;
    assign bus.IF_ins_type   = fifo_valid ? ent0_q.itype : 4'hF;
    assign bus.IF_ins_number = seq_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: latency-configurable memory, random stall/branch
// traffic, and a queue-based model of the delivered instruction stream.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_fetch_unit_if bus ();

    if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    // memory environment
    int   lat;
    int   mem_mode;
    int   mem_wait;
    logic req_seen;
    logic [31:0] prog [6];
    logic [5:0]  opc_tab [8];

    // reference model
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } ment_t;
    ment_t       mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    bit          m_req;
    bit          m_drop;
    logic [3:0]  m_seq;

    function automatic logic [3:0] ref_type(input logic [31:0] inst);
        logic [5:0] op;
        op = inst[31:26];
        if (op == 6'h00) return 4'd0;
        if (op == 6'h23) return 4'd1;
        if (op == 6'h2B) return 4'd2;
        if (op == 6'h04 || op == 6'h05) return 4'd3;
        if (op == 6'h02 || op == 6'h03) return 4'd4;
        return 4'd5;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (mem_mode == 0) begin
            w = a;
        end else if (mem_mode == 1) begin
            w = {opc_tab[int'((a >> 2) % 32'd8)], a[25:0]};
        end else begin
            w = prog[int'((a >> 2) % 32'd6)];
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc   = RESET_PC;
        m_addr = RESET_PC;
        m_req  = 1'b0;
        m_drop = 1'b0;
        m_seq  = 4'd0;
    endtask

    task automatic model_step();
        bit          br, ack, pop, push;
        logic [31:0] pc_n;
        int          cnt;
        if (rst) begin
            model_reset();
            return;
        end
        br   = bus.id_branch;
        ack  = bus.imem_ack;
        pop  = (mq.size() > 0) && !bus.id_stall && !br;
        push = m_req && !m_drop && ack && !br;
        pc_n = br ? bus.id_branch_target : (push ? m_pc + 32'd4 : m_pc);
        if (br) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back('{inst: bus.imem_rdata, pc4: m_pc + 32'd4});
        end
        if (pop) m_seq = m_seq + 4'd1;
        cnt = mq.size();
        if (m_req && ack) begin
            m_req  = br || m_drop || (cnt <= 1);
            m_drop = 1'b0;
            if (m_req) m_addr = pc_n;
        end else if (m_req) begin
            if (br) m_drop = 1'b1;
        end else begin
            m_req = !br && (cnt <= 1);
            if (m_req) m_addr = pc_n;
        end
        m_pc = pc_n;
    endtask

    task automatic model_check();
        bit v;
        v = (mq.size() > 0);
        chk("imem_req", bus.imem_req, m_req);
        if (m_req) chk("imem_addr", bus.imem_addr, m_addr);
        chk("if_valid", bus.if_valid, v);
        chk("if_inst", bus.if_inst, v ? mq[0].inst : 32'h0);
        chk("if_pc4", bus.if_pc4, v ? mq[0].pc4 : 32'h0);
        chk("IF_ins_type", bus.IF_ins_type, v ? ref_type(mq[0].inst) : 4'hF);
        chk("IF_ins_number", bus.IF_ins_number, m_seq);
    endtask

    task automatic mem_drive();
        req_seen = bus.imem_req;
        if (req_seen && mem_wait >= lat) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = mem_word(bus.imem_addr);
        end else begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = $urandom;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        if (rst) begin
            mem_wait = 0;
        end else if (req_seen) begin
            mem_wait = bus.imem_ack ? 0 : mem_wait + 1;
        end
        @(negedge clk);
        bus.id_branch = 1'b0;
        model_check();
        mem_drive();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) cycle();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_types [6];
        int pops;
        bit seen;

        prog[0] = 32'h8C01_0000; prog[1] = 32'hAC01_0000; prog[2] = 32'h1000_0001;
        prog[3] = 32'h0800_0000; prog[4] = 32'h0022_1820; prog[5] = 32'h2001_0005;
        opc_tab[0] = 6'h00; opc_tab[1] = 6'h23; opc_tab[2] = 6'h2B; opc_tab[3] = 6'h04;
        opc_tab[4] = 6'h05; opc_tab[5] = 6'h02; opc_tab[6] = 6'h03; opc_tab[7] = 6'h08;
        exp_types[0] = 4'd1; exp_types[1] = 4'd2; exp_types[2] = 4'd3;
        exp_types[3] = 4'd4; exp_types[4] = 4'd0; exp_types[5] = 4'd5;

        rst = 1'b1;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.id_stall = 1'b0;
        bus.id_branch = 1'b0;
        bus.id_branch_target = 32'h0;
        lat = 0;
        mem_mode = 0;
        mem_wait = 0;
        req_seen = 1'b0;
        model_reset();

        // reset values
        do_reset(2);
        chk("rst imem_req", bus.imem_req, 1'b0);
        chk("rst imem_addr", bus.imem_addr, RESET_PC);
        chk("rst if_valid", bus.if_valid, 1'b0);
        chk("rst if_inst", bus.if_inst, 32'h0);
        chk("rst if_pc4", bus.if_pc4, 32'h0);
        chk("rst IF_ins_type", bus.IF_ins_type, 4'hF);
        chk("rst IF_ins_number", bus.IF_ins_number, 4'd0);

        // zero-wait streaming, data = address
        cycle();
        chk("t1 req", bus.imem_req, 1'b1);
        chk("t1 addr0", bus.imem_addr, 32'h0);
        chk("t1 valid0", bus.if_valid, 1'b0);
        cycle();
        chk("t1 pc4 4", bus.if_pc4, 32'd4);
        chk("t1 num0", bus.IF_ins_number, 4'd0);
        chk("t1 addr4", bus.imem_addr, 32'd4);
        cycle();
        chk("t1 pc4 8", bus.if_pc4, 32'd8);
        chk("t1 num1", bus.IF_ins_number, 4'd1);
        cycle();
        chk("t1 pc4 12", bus.if_pc4, 32'd12);
        chk("t1 num2", bus.IF_ins_number, 4'd2);
        repeat (8) begin
            cycle();
            chk("t1 continuous valid", bus.if_valid, 1'b1);
        end

        // slow memory with decode stalled: FIFO fills, request stops
        lat = 2;
        bus.id_stall = 1'b1;
        do_reset(1);
        repeat (8) cycle();
        chk("t2 req dropped", bus.imem_req, 1'b0);
        chk("t2 frozen pc4", bus.if_pc4, 32'd4);
        chk("t2 frozen num", bus.IF_ins_number, 4'd0);
        bus.id_stall = 1'b0;
        repeat (20) cycle();

        // redirect while a 3-cycle request is outstanding
        lat = 3;
        do_reset(1);
        cycle();
        cycle();
        bus.id_branch = 1'b1;
        bus.id_branch_target = 32'h100;
        cycle();
        chk("t3 old addr held", bus.imem_addr, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (bus.if_valid) begin
                seen = 1'b1;
                chk("t3 first pc4 after redirect", bus.if_pc4, 32'h104);
            end
        end
        if (!seen) chk("t3 timeout waiting for valid", 32'd0, 32'd1);

        // redirect coincident with ack
        lat = 0;
        do_reset(1);
        repeat (3) cycle();
        chk("t4 ack pending", bus.imem_ack, 1'b1);
        bus.id_branch = 1'b1;
        bus.id_branch_target = 32'h100;
        cycle();
        chk("t4 addr target", bus.imem_addr, 32'h100);
        chk("t4 empty valid", bus.if_valid, 1'b0);
        chk("t4 empty inst", bus.if_inst, 32'h0);
        chk("t4 empty type", bus.IF_ins_type, 4'hF);
        cycle();
        chk("t4 target pc4", bus.if_pc4, 32'h104);

        // instruction classes and sequence number wrap
        mem_mode = 2;
        do_reset(1);
        pops = 0;
        for (int i = 0; i < 40 && pops < 18; i++) begin
            cycle();
            if (bus.if_valid) begin
                if (pops < 6) chk("t5 type", bus.IF_ins_type, exp_types[pops]);
                if (pops == 16) chk("t5 num wrap 0", bus.IF_ins_number, 4'd0);
                if (pops == 17) chk("t5 num wrap 1", bus.IF_ins_number, 4'd1);
                pops++;
            end
        end
        if (pops < 18) chk("t5 timeout pops", pops, 18);

        // reset during WAIT, stale ack afterwards
        mem_mode = 0;
        lat = 5;
        do_reset(1);
        cycle();
        cycle();
        chk("t6 in WAIT", bus.imem_req, 1'b1);
        rst = 1'b1;
        cycle();
        chk("t6 rst req", bus.imem_req, 1'b0);
        chk("t6 rst type", bus.IF_ins_type, 4'hF);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        cycle();
        rst = 1'b0;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        cycle();
        chk("t6 restart req", bus.imem_req, 1'b1);
        chk("t6 restart addr", bus.imem_addr, RESET_PC);
        chk("t6 nothing delivered", bus.if_valid, 1'b0);
        repeat (15) cycle();

        // randomized traffic
        mem_mode = 1;
        for (int it = 0; it < 4; it++) begin
            lat = $urandom_range(0, 3);
            do_reset(1);
            for (int c = 0; c < 400; c++) begin
                bus.id_stall = ($urandom_range(0, 99) < 30);
                if ($urandom_range(0, 99) < 6) begin
                    bus.id_branch = 1'b1;
                    case ($urandom_range(0, 2))
                        0: bus.id_branch_target = $urandom & 32'hFFFF_FFFC;
                        1: bus.id_branch_target = 32'hFFFF_FFF8;
                        default: bus.id_branch_target = $urandom;
                    endcase
                end
                if ($urandom_range(0, 99) < 3) lat = $urandom_range(0, 3);
                rst = ($urandom_range(0, 199) == 0);
                cycle();
            end
            rst = 1'b0;
            bus.id_stall = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
